// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_pkg : mode encodings, bar colour table and 640x480@60 default timing    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package vga_pkg;

  localparam logic [1:0] c_mode_solid   = 2'd0;
  localparam logic [1:0] c_mode_bars    = 2'd1;
  localparam logic [1:0] c_mode_checker = 2'd2;
  localparam logic [1:0] c_mode_grid    = 2'd3;

  localparam int c_def_h_active = 640;
  localparam int c_def_h_fp     = 16;
  localparam int c_def_h_sync   = 96;
  localparam int c_def_h_bp     = 48;
  localparam int c_def_v_active = 480;
  localparam int c_def_v_fp     = 10;
  localparam int c_def_v_sync   = 2;
  localparam int c_def_v_bp     = 33;

  // {R,G,B} channel enables, bar 0 at the left edge of the screen
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] rgb;
    rgb = 3'b000;
    case (idx)
      3'd0:    rgb = 3'b111;
      3'd1:    rgb = 3'b110;
      3'd2:    rgb = 3'b011;
      3'd3:    rgb = 3'b010;
      3'd4:    rgb = 3'b101;
      3'd5:    rgb = 3'b100;
      3'd6:    rgb = 3'b001;
      default: rgb = 3'b000;
    endcase
    return rgb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_axis_counter : one raster axis - position counter, wrap, active, sync   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module vga_axis_counter #(
  parameter int CNT_W      = 11,
  parameter int TOTAL      = 800,
  parameter int ACTIVE     = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_LEN   = 96,
  parameter bit POL        = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_wrap,
  output logic             o_active,
  output logic             o_sync
);

  // One extra bit so a sync window ending exactly at TOTAL still fits
  localparam logic [CNT_W:0] c_last       = (CNT_W+1)'(TOTAL - 1);
  localparam logic [CNT_W:0] c_active     = (CNT_W+1)'(ACTIVE);
  localparam logic [CNT_W:0] c_sync_start = (CNT_W+1)'(SYNC_START);
  localparam logic [CNT_W:0] c_sync_end   = (CNT_W+1)'(SYNC_START + SYNC_LEN);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_cnt_ext;

  assign w_cnt_ext = {1'b0, r_cnt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_wrap ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt    = r_cnt;
  assign o_wrap   = (w_cnt_ext == c_last);
  assign o_active = (w_cnt_ext < c_active);
  assign o_sync   = ((w_cnt_ext >= c_sync_start) && (w_cnt_ext < c_sync_end)) ? POL : ~POL;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_timing_gen_param : parametrised VGA timing, test patterns, aligned out  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module vga_timing_gen_param
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int H_ACTIVE  = c_def_h_active,
  parameter int H_FP      = c_def_h_fp,
  parameter int H_SYNC    = c_def_h_sync,
  parameter int H_BP      = c_def_h_bp,
  parameter int V_ACTIVE  = c_def_v_active,
  parameter int V_FP      = c_def_v_fp,
  parameter int V_SYNC    = c_def_v_sync,
  parameter int V_BP      = c_def_v_bp,
  parameter bit H_POL     = 1'b0,
  parameter bit V_POL     = 1'b0,
  parameter int CNT_W     = 11,
  parameter int COLOR_W   = 4,
  parameter int CELL_LOG2 = 5
) (
  input  logic               clk_50,
  input  logic               rst_o,
  input  logic [3:0]         sw,
  input  logic [1:0]         mode,
  output logic               pix_en,
  output logic               hsync,
  output logic               vsync,
  output logic [COLOR_W-1:0] R,
  output logic [COLOR_W-1:0] G,
  output logic [COLOR_W-1:0] B,
  output logic               video_on,
  output logic [CNT_W-1:0]   pixel_x,
  output logic [CNT_W-1:0]   pixel_y,
  output logic               frame_start
);

  localparam int                   c_div_w     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_div_w-1:0]   c_div_last  = c_div_w'(CLK_DIV - 1);
  localparam logic [COLOR_W-1:0]   c_full      = '1;
  localparam logic [COLOR_W-1:0]   c_half      = c_full >> 1;
  localparam logic [CNT_W-1:0]     c_cell_mask = CNT_W'((1 << CELL_LOG2) - 1);

  logic [c_div_w-1:0] r_div_cnt;
  logic               r_pix_en;
  logic [3:0]         r_sw_meta, r_sw_sync, r_sw_shadow;
  logic [1:0]         r_mode_meta, r_mode_sync, r_mode_shadow;

  logic [CNT_W-1:0]   w_h, w_v;
  logic               w_h_wrap, w_h_active, w_v_active, w_hsync, w_vsync, w_video;
  logic               w_shadow_load;
  logic [3:0]         w_sw_cur;
  logic [1:0]         w_mode_cur;

  always_ff @(posedge clk_50 or negedge rst_o) begin
    if (!rst_o) begin
      r_div_cnt   <= '0;
      r_pix_en    <= 1'b0;
      r_sw_meta   <= '0;
      r_sw_sync   <= '0;
      r_mode_meta <= '0;
      r_mode_sync <= '0;
    end else begin
      r_pix_en    <= (r_div_cnt == c_div_last);
      r_div_cnt   <= (r_div_cnt == c_div_last) ? '0 : r_div_cnt + c_div_w'(1);
      r_sw_meta   <= sw;
      r_sw_sync   <= r_sw_meta;
      r_mode_meta <= mode;
      r_mode_sync <= r_mode_meta;
    end
  end

  vga_axis_counter #(
    .CNT_W      (CNT_W),
    .TOTAL      (H_ACTIVE + H_FP + H_SYNC + H_BP),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_LEN   (H_SYNC),
    .POL        (H_POL)
  ) u_h_axis (
    .clk      (clk_50),
    .rst_n    (rst_o),
    .i_en     (r_pix_en),
    .o_cnt    (w_h),
    .o_wrap   (w_h_wrap),
    .o_active (w_h_active),
    .o_sync   (w_hsync)
  );

  vga_axis_counter #(
    .CNT_W      (CNT_W),
    .TOTAL      (V_ACTIVE + V_FP + V_SYNC + V_BP),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_LEN   (V_SYNC),
    .POL        (V_POL)
  ) u_v_axis (
    .clk      (clk_50),
    .rst_n    (rst_o),
    .i_en     (r_pix_en & w_h_wrap),
    .o_cnt    (w_v),
    .o_wrap   (),
    .o_active (w_v_active),
    .o_sync   (w_vsync)
  );

  assign w_video       = w_h_active & w_v_active;
  assign w_shadow_load = r_pix_en && (w_h == '0) && (w_v == '0);
  // The origin pixel already uses the settings being captured this edge
  assign w_sw_cur      = w_shadow_load ? r_sw_sync   : r_sw_shadow;
  assign w_mode_cur    = w_shadow_load ? r_mode_sync : r_mode_shadow;

  always_ff @(posedge clk_50 or negedge rst_o) begin
    if (!rst_o) begin
      r_sw_shadow   <= '0;
      r_mode_shadow <= '0;
    end else if (w_shadow_load) begin
      r_sw_shadow   <= r_sw_sync;
      r_mode_shadow <= r_mode_sync;
    end
  end

  logic [COLOR_W-1:0] w_level, w_sol_r, w_sol_g, w_sol_b, w_pat_r, w_pat_g, w_pat_b;
  logic [2:0]         w_bar_idx, w_bar_rgb;
  logic               w_on_cell, w_on_line;

  always_comb begin
    w_level = w_sw_cur[3] ? c_full : c_half;
    w_sol_r = w_sw_cur[0] ? w_level : '0;
    w_sol_g = w_sw_cur[1] ? w_level : '0;
    w_sol_b = w_sw_cur[2] ? w_level : '0;

    // Bar edges are constant thresholds at k*H_ACTIVE/8
    w_bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if ({1'b0, w_h} >= (CNT_W+1)'(k * H_ACTIVE / 8)) begin
        w_bar_idx = 3'(k);
      end
    end
    w_bar_rgb = bar_rgb(w_bar_idx);

    w_on_cell = w_h[CELL_LOG2] ^ w_v[CELL_LOG2];
    w_on_line = ((w_h & c_cell_mask) == '0) || ((w_v & c_cell_mask) == '0);

    w_pat_r = w_sol_r;
    w_pat_g = w_sol_g;
    w_pat_b = w_sol_b;
    case (w_mode_cur)
      c_mode_solid: ;
      c_mode_bars: begin
        w_pat_r = w_bar_rgb[2] ? c_full : '0;
        w_pat_g = w_bar_rgb[1] ? c_full : '0;
        w_pat_b = w_bar_rgb[0] ? c_full : '0;
      end
      c_mode_checker: begin
        if (!w_on_cell) begin
          w_pat_r = '0;
          w_pat_g = '0;
          w_pat_b = '0;
        end
      end
      default: begin
        if (w_on_line) begin
          w_pat_r = c_full;
          w_pat_g = c_full;
          w_pat_b = c_full;
        end
      end
    endcase
  end

  logic               r_hsync, r_vsync, r_video_on, r_frame_start;
  logic [COLOR_W-1:0] r_r, r_g, r_b;
  logic [CNT_W-1:0]   r_pixel_x, r_pixel_y;

  always_ff @(posedge clk_50 or negedge rst_o) begin
    if (!rst_o) begin
      r_hsync       <= ~H_POL;
      r_vsync       <= ~V_POL;
      r_video_on    <= 1'b0;
      r_r           <= '0;
      r_g           <= '0;
      r_b           <= '0;
      r_pixel_x     <= '0;
      r_pixel_y     <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_shadow_load;
      if (r_pix_en) begin
        r_hsync    <= w_hsync;
        r_vsync    <= w_vsync;
        r_video_on <= w_video;
        r_r        <= w_video ? w_pat_r : '0;
        r_g        <= w_video ? w_pat_g : '0;
        r_b        <= w_video ? w_pat_b : '0;
        r_pixel_x  <= w_h;
        r_pixel_y  <= w_v;
      end
    end
  end

  assign pix_en      = r_pix_en;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video_on;
  assign R           = r_r;
  assign G           = r_g;
  assign B           = r_b;
  assign pixel_x     = r_pixel_x;
  assign pixel_y     = r_pixel_y;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vga_timing_gen_param : two small-raster instances vs a raster model      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_vga_timing_gen_param;

  localparam int HA = 64, HFP = 4, HS = 8, HBP = 4, HT = HA + HFP + HS + HBP;
  localparam int VA = 24, VFP = 2, VS = 2, VBP = 2, VT = VA + VFP + VS + VBP;
  localparam int CL = 3;

  typedef struct packed {
    logic       pe, hs, vs, von;
    logic [3:0] r, g, b;
    logic [7:0] x, y;
    logic       fs;
  } rec_t;

  logic clk, rst_o;
  logic [3:0] sw;
  logic [1:0] mode;

  logic       pe0, hs0, vs0, von0, fs0, pe1, hs1, vs1, von1, fs1;
  logic [3:0] r0, g0, b0, r1, g1, b1;
  logic [7:0] x0, y0, x1, y1;

  vga_timing_gen_param #(
    .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .H_POL(1'b0), .V_POL(1'b0),
    .CNT_W(8), .COLOR_W(4), .CELL_LOG2(CL)
  ) u_dut0 (
    .clk_50(clk), .rst_o(rst_o), .sw(sw), .mode(mode), .pix_en(pe0), .hsync(hs0), .vsync(vs0),
    .R(r0), .G(g0), .B(b0), .video_on(von0), .pixel_x(x0), .pixel_y(y0), .frame_start(fs0)
  );

  vga_timing_gen_param #(
    .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .H_POL(1'b1), .V_POL(1'b0),
    .CNT_W(8), .COLOR_W(4), .CELL_LOG2(CL)
  ) u_dut1 (
    .clk_50(clk), .rst_o(rst_o), .sw(sw), .mode(mode), .pix_en(pe1), .hsync(hs1), .vsync(vs1),
    .R(r1), .G(g1), .B(b1), .video_on(von1), .pixel_x(x1), .pixel_y(y1), .frame_start(fs1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int tcnt     = 0;

  function automatic rec_t reset_rec(input bit hpol);
    rec_t e;
    e    = '0;
    e.hs = ~hpol;
    e.vs = 1'b1;
    return e;
  endfunction

  // Expected output for raster position (x,y) under the frame's mode/switch settings
  function automatic rec_t pixel_rec(input int x, input int y, input logic [1:0] m,
                                     input logic [3:0] s, input bit hpol);
    rec_t e;
    logic [3:0] lvl, cr, cg, cb;
    logic [2:0] rgb;
    int bar;
    e     = '0;
    e.x   = 8'(x);
    e.y   = 8'(y);
    e.von = (x < HA) && (y < VA);
    e.hs  = (x >= HA + HFP && x < HA + HFP + HS) ? hpol : ~hpol;
    e.vs  = (y >= VA + VFP && y < VA + VFP + VS) ? 1'b0 : 1'b1;
    lvl   = s[3] ? 4'hF : 4'h7;
    cr    = s[0] ? lvl : 4'h0;
    cg    = s[1] ? lvl : 4'h0;
    cb    = s[2] ? lvl : 4'h0;
    bar   = x / (HA / 8);
    case (bar)
      0: rgb = 3'b111;  1: rgb = 3'b110;  2: rgb = 3'b011;  3: rgb = 3'b010;
      4: rgb = 3'b101;  5: rgb = 3'b100;  6: rgb = 3'b001;  default: rgb = 3'b000;
    endcase
    case (m)
      2'd1: begin
        cr = rgb[2] ? 4'hF : 4'h0;
        cg = rgb[1] ? 4'hF : 4'h0;
        cb = rgb[0] ? 4'hF : 4'h0;
      end
      2'd2: if ((((x >> CL) ^ (y >> CL)) & 1) == 0) begin cr = 0; cg = 0; cb = 0; end
      2'd3: if ((x % (1 << CL)) == 0 || (y % (1 << CL)) == 0) begin cr = 4'hF; cg = 4'hF; cb = 4'hF; end
      default: ;
    endcase
    if (e.von) begin
      e.r = cr; e.g = cg; e.b = cb;
    end
    return e;
  endfunction

  rec_t q0[$], q1[$];
  int   mn   [2];
  logic [5:0] h1[2], h2[2], eff[2];
  rec_t last [2];

  // Reference model: pixel k of the raster appears one clock after the k-th strobe
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      rec_t e;
      int d, p, x, y;
      bit hp;
      d  = (i == 0) ? 2 : 1;
      hp = (i == 0) ? 1'b0 : 1'b1;
      if (!rst_o) begin
        mn[i] = 0; h1[i] = '0; h2[i] = '0; eff[i] = '0;
        e = reset_rec(hp);
      end else begin
        mn[i] = mn[i] + 1;
        e    = last[i];
        e.fs = 1'b0;
        if (mn[i] >= 2 && (mn[i] - 1) % d == 0) begin
          p = (mn[i] - 1) / d - 1;
          x = p % HT;
          y = (p / HT) % VT;
          if (x == 0 && y == 0) eff[i] = h2[i];
          e    = pixel_rec(x, y, eff[i][5:4], eff[i][3:0], hp);
          e.fs = (x == 0 && y == 0);
        end
        e.pe  = (mn[i] % d == 0);
        h2[i] = h1[i];
        h1[i] = {mode, sw};
      end
      last[i] = e;
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  end

  task automatic check(input int inst, input rec_t got, input rec_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL pixel inst%0d t=%0t got pe%b hs%b vs%b von%b rgb=%h%h%h xy=%0d,%0d fs%b required pe%b hs%b vs%b von%b rgb=%h%h%h xy=%0d,%0d fs%b",
               inst, $time, got.pe, got.hs, got.vs, got.von, got.r, got.g, got.b, got.x, got.y, got.fs,
               exp.pe, exp.hs, exp.vs, exp.von, exp.r, exp.g, exp.b, exp.x, exp.y, exp.fs);
    end
  endtask

  // Monitor: while reset is held the outputs must already be at reset values
  always @(negedge clk) begin
    rec_t e, got;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      if (!rst_o) e = reset_rec(1'b0);
      got = '{pe: pe0, hs: hs0, vs: vs0, von: von0, r: r0, g: g0, b: b0, x: x0, y: y0, fs: fs0};
      check(0, got, e);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      if (!rst_o) e = reset_rec(1'b1);
      got = '{pe: pe1, hs: hs1, vs: vs1, von: von1, r: r1, g: g1, b: b1, x: x1, y: y1, fs: fs1};
      check(1, got, e);
    end
  end

  task automatic wait_to(input int t);
    while (tcnt < t) begin
      @(posedge clk);
      tcnt++;
    end
    #2;
  endtask

  // Input changes stay away from the frame origins of both instances
  initial begin
    rst_o = 1'b0;
    mode  = 2'd0;
    sw    = 4'b0000;
    repeat (5) @(posedge clk);
    #2;
    rst_o = 1'b1;
    sw    = 4'b1001;
    tcnt  = 0;
    wait_to(6000);  sw   = 4'b0110;
    wait_to(10800); mode = 2'd1;
    wait_to(15600); mode = 2'd0; sw = 4'b1111;
    wait_to(20400); mode = 2'd2;
    for (int k = 0; k < 5; k++) begin
      wait_to((tcnt / 2400 + 1) * 2400 + int'($urandom_range(300, 2100)));
      mode = 2'($urandom_range(0, 3));
      sw   = 4'($urandom_range(0, 15));
    end
    wait_to((tcnt / 4800 + 1) * 4800 + 1500);
    rst_o = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    mode  = 2'd3;
    sw    = 4'b0101;
    rst_o = 1'b1;
    tcnt  = 0;
    wait_to(1200);  sw = 4'b1010;
    wait_to(10000);
    repeat (2) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
